wb_arbiter: RTL

- Schedules the single register-file write port and drives the 3-bit writeback-mux select.
- Three requesters compete for the port:
  - exec: single-cycle results (ALU, immediate, PC, SP).
  - mem: load responses.
  - io: IO read responses.
- Slow responders (mem, io) have priority and alternate round-robin. A starvation counter guarantees exec forward progress.
- Sits between the execute/memory/IO stages and the writeback mux + register file.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_rr2.sv | 40 ++++
 rtl/wb_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared writeback definitions: mux select codes, source enum and select legality helper.
package wb_pkg;

    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] WB_ALU = 3'b000;
    localparam logic [SEL_W-1:0] WB_IMM = 3'b001;
    localparam logic [SEL_W-1:0] WB_MEM = 3'b010;
    localparam logic [SEL_W-1:0] WB_IO  = 3'b011;
    localparam logic [SEL_W-1:0] WB_PC  = 3'b100;
    localparam logic [SEL_W-1:0] WB_SP  = 3'b101;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_EX,
        SRC_MEM,
        SRC_IO
    } wb_src_t;

    // Exec may only steer the mux to its own single-cycle sources.
    function automatic logic ex_sel_legal(input logic [SEL_W-1:0] sel);
        return (sel == WB_ALU) || (sel == WB_IMM) || (sel == WB_PC) || (sel == WB_SP);
    endfunction

endpackage

// File: rtl/wb_rr2.sv
// Two-way round-robin picker between the slow sources; owns the rr_mem_first flop.
module wb_rr2
    import wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic b_valid,
    input  logic a_won,
    input  logic b_won,
    output logic a_pick,
    output logic b_pick
);

    logic rr_mem_first;

    // Turn only passes on an actual slow-source grant; forced exec grants leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_mem_first <= 1'b1;
        end else if (a_won) begin
            rr_mem_first <= 1'b0;
        end else if (b_won) begin
            rr_mem_first <= 1'b1;
        end
    end

    always_comb begin
        a_pick = 1'b0;
        b_pick = 1'b0;
        if (a_valid && b_valid) begin
            a_pick = rr_mem_first;
            b_pick = !rr_mem_first;
        end else begin
            a_pick = a_valid;
            b_pick = b_valid;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: slow sources round-robin first, exec protected by a starvation counter.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned REG_AW     = 3,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [SEL_W-1:0]  ex_sel,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              ex_ready,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    output logic              mem_ready,
    input  logic              io_valid,
    input  logic [REG_AW-1:0] io_rd,
    output logic              io_ready,
    output logic [SEL_W-1:0]  wb_sel,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_we,
    output logic              sel_err
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_ex;
    logic             mem_pick;
    logic             io_pick;
    wb_src_t          src;

    assign force_ex = ex_valid && (starve_cnt == STARVE_LIM);

    wb_rr2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .a_valid (mem_valid),
        .b_valid (io_valid),
        .a_won   (src == SRC_MEM),
        .b_won   (src == SRC_IO),
        .a_pick  (mem_pick),
        .b_pick  (io_pick)
    );

    always_comb begin
        src = SRC_NONE;
        if (!rst) begin
            if (force_ex) begin
                src = SRC_EX;
            end else if (mem_pick) begin
                src = SRC_MEM;
            end else if (io_pick) begin
                src = SRC_IO;
            end else if (ex_valid) begin
                src = SRC_EX;
            end
        end
    end

    always_comb begin
        ex_ready  = 1'b0;
        mem_ready = 1'b0;
        io_ready  = 1'b0;
        wb_we     = 1'b0;
        wb_sel    = WB_ALU;
        wb_rd     = '0;
        sel_err   = 1'b0;
        unique case (src)
            SRC_EX: begin
                ex_ready = 1'b1;
                wb_we    = 1'b1;
                wb_rd    = ex_rd;
                // Illegal codes still write, but through the ALU path, and flag the error.
                if (ex_sel_legal(ex_sel)) begin
                    wb_sel = ex_sel;
                end else begin
                    sel_err = 1'b1;
                end
            end
            SRC_MEM: begin
                mem_ready = 1'b1;
                wb_we     = 1'b1;
                wb_sel    = WB_MEM;
                wb_rd     = mem_rd;
            end
            SRC_IO: begin
                io_ready = 1'b1;
                wb_we    = 1'b1;
                wb_sel   = WB_IO;
                wb_rd    = io_rd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!ex_valid || (src == SRC_EX)) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule
